dmem_arbiter: RTL and testbench

//  Shares the single-ported data memory between the core LSU port (port C) and a

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Purpose: shares single-ported dmem between core LSU (C) and burst loader/debug (L).
// Latency: grant is combinational; read data returns on the requester's port 1 cycle after issue.
// Backpressure: C waits on c_gnt; L write beats wait on l_wready; C wins unless L has waited MAX_WAIT grants.
module dmem_arbiter #(
    parameter int LEN_W    = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_req,
    input  logic [3:0]       c_we,
    input  logic [31:0]      c_addr,
    input  logic [31:0]      c_wdata,
    output logic             c_gnt,
    output logic             c_rvalid,
    output logic [31:0]      c_rdata,
    input  logic             l_start,
    input  logic             l_write,
    input  logic [31:0]      l_addr,
    input  logic [LEN_W-1:0] l_len,
    input  logic [31:0]      l_wdata,
    input  logic             l_wvalid,
    output logic             l_wready,
    output logic             l_rvalid,
    output logic [31:0]      l_rdata,
    output logic             l_busy,
    output logic             l_done,
    output logic             m_en,
    output logic [3:0]       m_we,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       cur_addr;
    logic [LEN_W-1:0]  beats_left;
    logic              is_write;
    logic [WC_W-1:0]   wait_cnt;
    logic              tag_vld;
    logic              tag_l;
    logic [31:0]       c_rdata_q;
    logic [31:0]       l_rdata_q;
    logic              l_ready;
    logic              force_l;
    logic              l_beat;

    // Arbitration, memory mux and burst sequencing decisions for this cycle.
    always_comb begin
        state_nxt = state;
        l_ready   = (state == S_BURST) && (beats_left != '0) && (!is_write || l_wvalid);
        force_l   = l_ready && (wait_cnt == WC_W'(MAX_WAIT));
        c_gnt     = c_req && !force_l;
        l_beat    = !c_gnt && l_ready;
        l_wready  = l_beat && is_write;
        m_en      = 1'b0;
        m_we      = 4'b0000;
        m_addr    = 32'd0;
        m_wdata   = 32'd0;
        if (c_gnt) begin
            m_en    = 1'b1;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (l_beat) begin
            m_en    = 1'b1;
            m_we    = is_write ? 4'b1111 : 4'b0000;
            m_addr  = cur_addr;
            m_wdata = is_write ? l_wdata : 32'd0;
        end
        case (state)
            S_IDLE: begin
                if (l_start) begin
                    state_nxt = (l_len != '0) ? S_BURST : S_DONE;
                end
            end
            S_BURST: begin
                // Write bursts finish as the last beat issues; read bursts finish
                // in the cycle the last beat's data comes back (beats_left already 0).
                if ((l_beat && is_write && beats_left == LEN_W'(1)) || beats_left == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read return routing: the owner tag picks the port, rdata holds between returns.
    always_comb begin
        c_rvalid = tag_vld && !tag_l;
        l_rvalid = tag_vld && tag_l;
        c_rdata  = c_rvalid ? m_rdata : c_rdata_q;
        l_rdata  = l_rvalid ? m_rdata : l_rdata_q;
        l_busy   = (state == S_BURST) || l_rvalid;
        l_done   = (state == S_DONE);
    end

    // State, burst address/count, starvation counter and read-owner tag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cur_addr   <= 32'd0;
            beats_left <= '0;
            is_write   <= 1'b0;
            wait_cnt   <= '0;
            tag_vld    <= 1'b0;
            tag_l      <= 1'b0;
            c_rdata_q  <= 32'd0;
            l_rdata_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && l_start) begin
                cur_addr   <= l_addr & 32'hFFFF_FFFC;
                beats_left <= l_len;
                is_write   <= l_write;
            end else if (l_beat) begin
                cur_addr   <= cur_addr + 32'd4;
                beats_left <= beats_left - LEN_W'(1);
            end
            if (state == S_IDLE || l_beat) begin
                wait_cnt <= '0;
            end else if (c_gnt && l_ready && wait_cnt != WC_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WC_W'(1);
            end
            tag_vld <= m_en && (m_we == 4'b0000);
            tag_l   <= l_beat;
            if (c_rvalid) begin
                c_rdata_q <= m_rdata;
            end
            if (l_rvalid) begin
                l_rdata_q <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed bench for dmem_arbiter with a 1-cycle registered memory model.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: exercised through c_req priority, l_wvalid stalls and forced L beats.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req;
    logic [3:0]  c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic        l_start;
    logic        l_write;
    logic [31:0] l_addr;
    logic [7:0]  l_len;
    logic [31:0] l_wdata;
    logic        l_wvalid;
    logic        l_wready;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        l_busy;
    logic        l_done;
    logic        m_en;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.LEN_W(8), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_start(l_start), .l_write(l_write), .l_addr(l_addr), .l_len(l_len),
        .l_wdata(l_wdata), .l_wvalid(l_wvalid), .l_wready(l_wready),
        .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_busy(l_busy), .l_done(l_done),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: preloaded while reset is low, registered read, full-word writes.
    always @(posedge clk) begin
        if (!reset) begin
            mem[4]    <= 32'hDEAD_BEEF;
            mem[128]  <= 32'h0000_1000;
            mem[129]  <= 32'h0000_1001;
            mem[130]  <= 32'h0000_1002;
            mem[131]  <= 32'h0000_1003;
            mem[192]  <= 32'h0000_3000;
            mem[193]  <= 32'h0000_3004;
            mem[1023] <= 32'hCAFE_0001;
            mem[0]    <= 32'hCAFE_0000;
        end else if (m_en) begin
            if (m_we == 4'b0000) m_rdata <= mem[m_addr[11:2]];
            else if (m_we == 4'b1111) mem[m_addr[11:2]] <= m_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 6;
        if (c_gnt !== 1'b0 || m_en !== 1'b0) begin errors++; $display("FAIL reset_mem: c_gnt=%b m_en=%b want 0 0", c_gnt, m_en); end
        if (l_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b want 0", l_busy); end
        if (l_done !== 1'b0) begin errors++; $display("FAIL reset_done: %b want 0", l_done); end
        if (c_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: c=%b l=%b want 0 0", c_rvalid, l_rvalid); end
        if (c_rdata !== 32'd0) begin errors++; $display("FAIL reset_c_rdata: %h want 0", c_rdata); end
        if (m_addr !== 32'd0 || m_we !== 4'd0 || l_wready !== 1'b0) begin errors++; $display("FAIL reset_outs: m_addr=%h m_we=%h l_wready=%b want 0", m_addr, m_we, l_wready); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_c_read();
        c_req = 1'b1; c_addr = 32'h10; c_we = 4'b0000;
        @(negedge clk);
        checks += 2;
        if (c_gnt !== 1'b1 || m_en !== 1'b1) begin errors++; $display("FAIL cread_gnt: c_gnt=%b m_en=%b want 1 1", c_gnt, m_en); end
        if (m_addr !== 32'h10 || m_we !== 4'b0000) begin errors++; $display("FAIL cread_addr: %h/%h want 10/0", m_addr, m_we); end
        tick();
        c_req = 1'b0;
        @(negedge clk);
        checks += 2;
        if (c_rvalid !== 1'b1 || l_rvalid !== 1'b0) begin errors++; $display("FAIL cread_rvalid: c=%b l=%b want 1 0", c_rvalid, l_rvalid); end
        if (c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cread_data: %h want deadbeef", c_rdata); end
        tick();
        @(negedge clk);
        checks += 1;
        if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cread_hold: rvalid=%b data=%h want 0 deadbeef", c_rvalid, c_rdata); end
        tick();
    endtask

    task automatic test_l_write_burst();
        l_start = 1'b1; l_write = 1'b1; l_addr = 32'h103; l_len = 8'd3; l_wvalid = 1'b1; l_wdata = 32'hA0;
        @(negedge clk);
        checks += 1;
        if (m_en !== 1'b0) begin errors++; $display("FAIL wburst_idle_men: %b want 0", m_en); end
        tick();
        l_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            l_wdata = 32'hA0 + 32'(i);
            @(negedge clk);
            checks += 2;
            if (m_en !== 1'b1 || l_wready !== 1'b1 || m_we !== 4'hF) begin errors++; $display("FAIL wburst_beat%0d: m_en=%b l_wready=%b m_we=%h want 1 1 f", i, m_en, l_wready, m_we); end
            if (m_addr !== 32'h100 + 32'(4 * i) || m_wdata !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL wburst_addr%0d: addr=%h data=%h want %h %h", i, m_addr, m_wdata, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i)); end
            tick();
        end
        l_wvalid = 1'b0;
        @(negedge clk);
        checks += 1;
        if (l_done !== 1'b1 || m_en !== 1'b0) begin errors++; $display("FAIL wburst_done: l_done=%b m_en=%b want 1 0", l_done, m_en); end
        tick();
        @(negedge clk);
        checks += 2;
        if (l_done !== 1'b0 || l_busy !== 1'b0) begin errors++; $display("FAIL wburst_after: l_done=%b l_busy=%b want 0 0", l_done, l_busy); end
        if (mem[64] !== 32'hA0 || mem[65] !== 32'hA1 || mem[66] !== 32'hA2) begin errors++; $display("FAIL wburst_mem: %h %h %h want a0 a1 a2", mem[64], mem[65], mem[66]); end
        tick();
    endtask

    task automatic test_starvation_guard();
        logic prev_c;
        logic exp_cg;
        logic exp_lv;
        c_req = 1'b1; c_addr = 32'h10; c_we = 4'b0000;
        l_start = 1'b1; l_write = 1'b0; l_addr = 32'h200; l_len = 8'd4;
        @(negedge clk);
        checks += 1;
        if (c_gnt !== 1'b1) begin errors++; $display("FAIL starve_idle_gnt: %b want 1", c_gnt); end
        tick();
        l_start = 1'b0;
        prev_c = 1'b1;
        for (int k = 0; k < 22; k++) begin
            exp_cg = (k < 20) ? ((k % 5) != 4) : 1'b1;
            exp_lv = (k > 0) && ((k % 5) == 0);
            @(negedge clk);
            checks += 4;
            if (c_gnt !== exp_cg) begin errors++; $display("FAIL starve_gnt k=%0d: %b want %b", k, c_gnt, exp_cg); end
            if (c_rvalid !== prev_c || (prev_c && c_rdata !== 32'hDEAD_BEEF)) begin errors++; $display("FAIL starve_crv k=%0d: %b/%h want %b/deadbeef", k, c_rvalid, c_rdata, prev_c); end
            if (l_rvalid !== exp_lv || (exp_lv && l_rdata !== 32'h1000 + 32'(k / 5 - 1))) begin errors++; $display("FAIL starve_lrv k=%0d: %b/%h want %b/%h", k, l_rvalid, l_rdata, exp_lv, 32'h1000 + 32'(k / 5 - 1)); end
            if (l_done !== (k == 21)) begin errors++; $display("FAIL starve_done k=%0d: %b want %b", k, l_done, k == 21); end
            if (!exp_cg) begin
                checks += 1;
                if (m_en !== 1'b1 || m_addr !== 32'h200 + 32'(4 * (k / 5))) begin errors++; $display("FAIL starve_laddr k=%0d: %b/%h want 1/%h", k, m_en, m_addr, 32'h200 + 32'(4 * (k / 5))); end
            end
            prev_c = exp_cg;
            tick();
        end
        c_req = 1'b0;
        tick();
    endtask

    task automatic test_interleave();
        l_start = 1'b1; l_write = 1'b0; l_addr = 32'h300; l_len = 8'd2;
        tick();
        l_start = 1'b0;
        c_req = 1'b1; c_addr = 32'h10;
        @(negedge clk);
        checks += 1;
        if (c_gnt !== 1'b1 || m_addr !== 32'h10) begin errors++; $display("FAIL ilv_c0: gnt=%b addr=%h want 1 10", c_gnt, m_addr); end
        tick();
        c_req = 1'b0;
        @(negedge clk);
        checks += 2;
        if (m_en !== 1'b1 || m_addr !== 32'h300) begin errors++; $display("FAIL ilv_l0: en=%b addr=%h want 1 300", m_en, m_addr); end
        if (c_rvalid !== 1'b1 || l_rvalid !== 1'b0 || c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ilv_ret_c0: c=%b l=%b d=%h want 1 0 deadbeef", c_rvalid, l_rvalid, c_rdata); end
        tick();
        c_req = 1'b1; c_addr = 32'h100;
        @(negedge clk);
        checks += 2;
        if (c_gnt !== 1'b1) begin errors++; $display("FAIL ilv_c1: gnt=%b want 1", c_gnt); end
        if (l_rvalid !== 1'b1 || c_rvalid !== 1'b0 || l_rdata !== 32'h3000) begin errors++; $display("FAIL ilv_ret_l0: l=%b c=%b d=%h want 1 0 3000", l_rvalid, c_rvalid, l_rdata); end
        tick();
        c_req = 1'b0;
        @(negedge clk);
        checks += 2;
        if (m_addr !== 32'h304) begin errors++; $display("FAIL ilv_l1: addr=%h want 304", m_addr); end
        if (c_rvalid !== 1'b1 || l_rvalid !== 1'b0 || c_rdata !== 32'hA0) begin errors++; $display("FAIL ilv_ret_c1: c=%b l=%b d=%h want 1 0 a0", c_rvalid, l_rvalid, c_rdata); end
        tick();
        @(negedge clk);
        checks += 1;
        if (l_rvalid !== 1'b1 || c_rvalid !== 1'b0 || l_rdata !== 32'h3004) begin errors++; $display("FAIL ilv_ret_l1: l=%b c=%b d=%h want 1 0 3004", l_rvalid, c_rvalid, l_rdata); end
        tick();
        @(negedge clk);
        checks += 1;
        if (l_done !== 1'b1) begin errors++; $display("FAIL ilv_done: %b want 1", l_done); end
        tick();
    endtask

    task automatic test_zero_len();
        l_start = 1'b1; l_write = 1'b0; l_len = 8'd0; l_addr = 32'h600;
        @(negedge clk);
        checks += 1;
        if (m_en !== 1'b0 || l_done !== 1'b0) begin errors++; $display("FAIL zlen_start: en=%b done=%b want 0 0", m_en, l_done); end
        tick();
        l_start = 1'b0;
        @(negedge clk);
        checks += 1;
        if (l_done !== 1'b1 || m_en !== 1'b0 || l_busy !== 1'b0) begin errors++; $display("FAIL zlen_done: done=%b en=%b busy=%b want 1 0 0", l_done, m_en, l_busy); end
        tick();
        @(negedge clk);
        checks += 1;
        if (l_done !== 1'b0) begin errors++; $display("FAIL zlen_pulse: %b want 0", l_done); end
        // write burst stalled on l_wvalid, with a second l_start that must be ignored
        l_start = 1'b1; l_write = 1'b1; l_addr = 32'h400; l_len = 8'd2; l_wvalid = 1'b0;
        tick();
        l_write = 1'b0; l_addr = 32'h500; l_len = 8'd5;
        @(negedge clk);
        checks += 1;
        if (l_busy !== 1'b1 || m_en !== 1'b0 || l_wready !== 1'b0) begin errors++; $display("FAIL ign_stall: busy=%b en=%b wready=%b want 1 0 0", l_busy, m_en, l_wready); end
        tick();
        l_start = 1'b0; l_wvalid = 1'b1; l_wdata = 32'h55;
        @(negedge clk);
        checks += 1;
        if (m_addr !== 32'h400 || l_wready !== 1'b1 || m_we !== 4'hF) begin errors++; $display("FAIL ign_beat0: addr=%h wready=%b we=%h want 400 1 f", m_addr, l_wready, m_we); end
        tick();
        @(negedge clk);
        checks += 1;
        if (m_addr !== 32'h404 || l_wready !== 1'b1) begin errors++; $display("FAIL ign_beat1: addr=%h wready=%b want 404 1", m_addr, l_wready); end
        tick();
        l_wvalid = 1'b0;
        @(negedge clk);
        checks += 1;
        if (l_done !== 1'b1) begin errors++; $display("FAIL ign_done: %b want 1", l_done); end
        tick();
        @(negedge clk);
        checks += 1;
        if (l_done !== 1'b0 || m_en !== 1'b0 || l_busy !== 1'b0) begin errors++; $display("FAIL ign_idle: done=%b en=%b busy=%b want 0 0 0", l_done, m_en, l_busy); end
        tick();
    endtask

    task automatic test_wrap_and_reset();
        l_start = 1'b1; l_write = 1'b0; l_addr = 32'hFFFF_FFFC; l_len = 8'd2;
        tick();
        l_start = 1'b0;
        @(negedge clk);
        checks += 1;
        if (m_en !== 1'b1 || m_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_beat0: en=%b addr=%h want 1 fffffffc", m_en, m_addr); end
        tick();
        @(negedge clk);
        checks += 2;
        if (m_en !== 1'b1 || m_addr !== 32'h0) begin errors++; $display("FAIL wrap_beat1: en=%b addr=%h want 1 0", m_en, m_addr); end
        if (l_rvalid !== 1'b1 || l_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL wrap_ret0: %b/%h want 1/cafe0001", l_rvalid, l_rdata); end
        tick();
        @(negedge clk);
        checks += 1;
        if (l_rvalid !== 1'b1 || l_rdata !== 32'hCAFE_0000 || m_en !== 1'b0) begin errors++; $display("FAIL wrap_ret1: %b/%h en=%b want 1/cafe0000 0", l_rvalid, l_rdata, m_en); end
        tick();
        @(negedge clk);
        checks += 1;
        if (l_done !== 1'b1) begin errors++; $display("FAIL wrap_done: %b want 1", l_done); end
        tick();
        // reset lands while the first read beat of a new burst is in flight
        l_start = 1'b1; l_addr = 32'h200; l_len = 8'd4;
        tick();
        l_start = 1'b0;
        @(negedge clk);
        checks += 1;
        if (m_en !== 1'b1 || m_addr !== 32'h200) begin errors++; $display("FAIL rst_beat0: en=%b addr=%h want 1 200", m_en, m_addr); end
        reset = 1'b0;
        tick();
        @(negedge clk);
        checks += 3;
        if (l_rvalid !== 1'b0 || c_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: l=%b c=%b want 0 0", l_rvalid, c_rvalid); end
        if (m_en !== 1'b0 || l_busy !== 1'b0 || l_done !== 1'b0) begin errors++; $display("FAIL rst_outs: en=%b busy=%b done=%b want 0 0 0", m_en, l_busy, l_done); end
        if (l_rdata !== 32'd0 || c_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: l=%h c=%h want 0 0", l_rdata, c_rdata); end
        reset = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks += 1;
            if (l_done !== 1'b0 || l_rvalid !== 1'b0 || m_en !== 1'b0) begin errors++; $display("FAIL rst_quiet k=%0d: done=%b rv=%b en=%b want 0 0 0", k, l_done, l_rvalid, m_en); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        c_req = 1'b0; c_we = 4'b0000; c_addr = 32'd0; c_wdata = 32'd0;
        l_start = 1'b0; l_write = 1'b0; l_addr = 32'd0; l_len = 8'd0;
        l_wdata = 32'd0; l_wvalid = 1'b0;
        tick();
        tick();
        test_reset();
        test_c_read();
        test_l_write_burst();
        test_starvation_guard();
        test_interleave();
        test_zero_len();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
